// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg: opcode/funct constants and types for the decode stage.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/md_busy_tracker.sv
// +----------------------------------------------------------------------+
// | md_busy_tracker: IDLE/BUSY occupancy FSM for the mult/div unit.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module md_busy_tracker #(
    parameter int MD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic md_busy
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t          r_state_q;
    md_state_t          w_state_d;
    logic [CNT_W-1:0]   r_cnt_q;
    logic [CNT_W-1:0]   w_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Counter loads MD_CYCLES-1 so BUSY spans exactly MD_CYCLES cycles.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            IDLE: begin
                if (issue) begin
                    w_state_d = BUSY;
                    w_cnt_d   = CNT_W'(MD_CYCLES - 1);
                end
            end
            BUSY: begin
                if (r_cnt_q == '0) begin
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (r_state_q == BUSY);

endmodule

`default_nettype wire

// File: rtl/id_pipe_ctrl.sv
// +----------------------------------------------------------------------+
// | id_pipe_ctrl: IF/ID register, load-use/mult-div stalls, squashing.   |
// | Option macro: BRANCH_DELAY_SLOT_EN (redirect keeps the delay slot).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module id_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        if_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        pc_write,
    output logic        ex_bubble,
    output logic        md_busy
);

    logic [31:0] r_id_instr_q, w_id_instr_d;
    logic [31:0] r_id_pc4_q,   w_id_pc4_d;
    logic        r_id_valid_q, w_id_valid_d;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    reg_idx_t    w_rs;
    reg_idx_t    w_rt;
    logic        w_uses_rt;
    logic        w_is_md;
    logic        w_is_hilo;
    logic        w_jump;
    logic        w_stall_lu;
    logic        w_stall_md;
    logic        w_stall;
    logic        w_redirect;
    logic        w_md_issue;
    logic        w_md_busy;

    assign w_op    = r_id_instr_q[31:26];
    assign w_funct = r_id_instr_q[5:0];
    assign w_rs    = r_id_instr_q[25:21];
    assign w_rt    = r_id_instr_q[20:16];

    assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                       (w_op == OP_BNE)   || (w_op == OP_SW);
    assign w_is_md   = (w_op == OP_RTYPE) &&
                       ((w_funct == FN_MULT) || (w_funct == FN_MULTU) ||
                        (w_funct == FN_DIV)  || (w_funct == FN_DIVU));
    assign w_is_hilo = (w_op == OP_RTYPE) &&
                       ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
    assign w_jump    = r_id_valid_q &&
                       ((w_op == OP_J) || (w_op == OP_JAL) ||
                        ((w_op == OP_RTYPE) && (w_funct == FN_JR)));

    assign w_stall_lu = r_id_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == w_rs) || (w_uses_rt && (ex_rt == w_rt)));
    assign w_stall_md = r_id_valid_q && w_md_busy && (w_is_md || w_is_hilo);
    assign w_stall    = w_stall_lu || w_stall_md;
    assign w_redirect = !w_stall && (w_jump || (r_id_valid_q && branch_taken));
    assign w_md_issue = r_id_valid_q && w_is_md && !w_stall;

    md_busy_tracker #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue   (w_md_issue),
        .md_busy (w_md_busy)
    );

    // Stall wins over redirect; a held branch re-evaluates once released.
    always_comb begin
        w_id_instr_d = if_valid ? if_instr : NOP_INSTR;
        w_id_pc4_d   = if_pc4;
        w_id_valid_d = if_valid;
        if (w_stall) begin
            w_id_instr_d = r_id_instr_q;
            w_id_pc4_d   = r_id_pc4_q;
            w_id_valid_d = r_id_valid_q;
        end else if (w_redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
            w_id_instr_d = if_valid ? if_instr : NOP_INSTR;
            w_id_pc4_d   = if_pc4;
            w_id_valid_d = if_valid;
`else
            w_id_instr_d = NOP_INSTR;
            w_id_pc4_d   = 32'h0;
            w_id_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr_q <= NOP_INSTR;
            r_id_pc4_q   <= 32'h0;
            r_id_valid_q <= 1'b0;
        end else begin
            r_id_instr_q <= w_id_instr_d;
            r_id_pc4_q   <= w_id_pc4_d;
            r_id_valid_q <= w_id_valid_d;
        end
    end

    assign id_instr  = r_id_instr_q;
    assign id_pc4    = r_id_pc4_q;
    assign id_valid  = r_id_valid_q;
    assign pc_write  = !w_stall;
    assign ex_bubble = w_stall;
    assign md_busy   = w_md_busy;

endmodule

`default_nettype wire
